// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for a single registered 8-bit memory port.
// Fetch is read-only; execute may read or write. Grants are made only in IDLE.
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int RR = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  input  logic          e_req,
  input  logic          e_we,
  input  logic [AW-1:0] e_addr,
  input  logic [DW-1:0] e_wdata,
  output logic          e_ack,
  output logic [DW-1:0] e_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RDWAIT = 2'd2;
  localparam logic [1:0] ACK    = 2'd3;

  logic [1:0] state;
  logic       owner;     // 1 = execute owns the current transaction
  logic       last;      // 1 = execute was served last
  logic       is_write;
  logic       grant_e;

  // Execute wins if it is alone, or on a tie when round-robin says fetch went last.
  always_comb begin
    grant_e = 1'b0;
    if (e_req && !f_req) begin
      grant_e = 1'b1;
    end else if (e_req && f_req && (RR != 0) && !last) begin
      grant_e = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      is_write  <= 1'b0;
      f_ack     <= 1'b0;
      e_ack     <= 1'b0;
      f_rdata   <= '0;
      e_rdata   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      f_ack <= 1'b0;
      e_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (f_req || e_req) begin
            state    <= ACCESS;
            owner    <= grant_e;
            last     <= grant_e;
            is_write <= grant_e && e_we;
            mem_addr <= grant_e ? e_addr : f_addr;
            if (grant_e && e_we) begin
              mem_wdata <= e_wdata;
              mem_we    <= 1'b1;
            end
          end
        end
        ACCESS: begin
          mem_we <= 1'b0;
          if (is_write) begin
            state <= ACK;
            e_ack <= 1'b1;
          end else begin
            state <= RDWAIT;
          end
        end
        RDWAIT: begin
          state <= ACK;
          if (owner) begin
            e_rdata <= mem_rdata;
            e_ack   <= 1'b1;
          end else begin
            f_rdata <= mem_rdata;
            f_ack   <= 1'b1;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a round-robin instance and a fixed-priority instance,
// each behind a small memory model whose unwritten contents are addr ^ 0xB5.
module tb_mem_arbiter;

  logic       clk;
  logic       rst_n;
  logic       f_req, e_req, e_we;
  logic [7:0] f_addr, e_addr, e_wdata;
  logic       f_ack, e_ack, mem_we, busy;
  logic [7:0] f_rdata, e_rdata, mem_addr, mem_wdata, mem_rdata;

  logic       p_f_req, p_e_req, p_e_we;
  logic [7:0] p_f_addr, p_e_addr, p_e_wdata;
  logic       p_f_ack, p_e_ack, p_mem_we, p_busy;
  logic [7:0] p_f_rdata, p_e_rdata, p_mem_addr, p_mem_wdata, p_mem_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         is_e;
    logic [7:0] data;
  } exp_t;
  exp_t sb_q[$];

  mem_arbiter #(.AW(8), .DW(8), .RR(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
    .e_ack(e_ack), .e_rdata(e_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.AW(8), .DW(8), .RR(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .f_req(p_f_req), .f_addr(p_f_addr), .f_ack(p_f_ack), .f_rdata(p_f_rdata),
    .e_req(p_e_req), .e_we(p_e_we), .e_addr(p_e_addr), .e_wdata(p_e_wdata),
    .e_ack(p_e_ack), .e_rdata(p_e_rdata),
    .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata), .mem_we(p_mem_we),
    .mem_rdata(p_mem_rdata), .busy(p_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: written locations overlay the addr ^ 0xB5 background pattern.
  logic [7:0] wr_data [256];
  logic       wr_valid[256];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) wr_valid[i] <= 1'b0;
    end else if (mem_we) begin
      wr_valid[mem_addr] <= 1'b1;
      wr_data[mem_addr]  <= mem_wdata;
    end
    mem_rdata   <= wr_valid[mem_addr] ? wr_data[mem_addr] : (mem_addr ^ 8'hB5);
    p_mem_rdata <= p_mem_addr ^ 8'hB5;
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, f_ack, e_ack, mem_we} !== 4'b0)
      $display("FAIL reset_ctrl: got %b expected 0000", {busy, f_ack, e_ack, mem_we});
    checks++;
    if ({mem_addr, mem_wdata, f_rdata, e_rdata} !== 32'h0)
      $display("FAIL reset_data: got %h expected 00000000", {mem_addr, mem_wdata, f_rdata, e_rdata});
    if ({busy, f_ack, e_ack, mem_we} !== 4'b0) errors++;
    if ({mem_addr, mem_wdata, f_rdata, e_rdata} !== 32'h0) errors++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_fetch();
    exp_t e;
    f_addr = 8'h10;
    f_req  = 1'b1;
    sb_q.push_back('{1'b0, 8'hA5});
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== (c >= 1 && c <= 3)) begin
        errors++; $display("FAIL fetch_busy c%0d: got %b expected %b", c, busy, (c >= 1 && c <= 3));
      end
      checks++;
      if (f_ack !== (c == 3) || e_ack !== 1'b0) begin
        errors++; $display("FAIL fetch_ack c%0d: got f%b e%b expected f%b e0", c, f_ack, e_ack, (c == 3));
      end
      if (c == 1) begin
        checks++;
        if (mem_addr !== 8'h10) begin
          errors++; $display("FAIL fetch_addr: got %h expected 10", mem_addr);
        end
      end
      if (f_ack || e_ack) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL fetch_sb: got unexpected ack expected none");
        end else begin
          e = sb_q.pop_front();
          if (e_ack !== e.is_e || (e.is_e ? e_rdata : f_rdata) !== e.data) begin
            errors++; $display("FAIL fetch_sb: got e%b %h expected e%b %h", e_ack, (e.is_e ? e_rdata : f_rdata), e.is_e, e.data);
          end
        end
      end
      if (c == 3) f_req = 1'b0;
      $display("single_fetch c%0d busy=%b f_ack=%b f_rdata=%h", c, busy, f_ack, f_rdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    exp_t e;
    e_addr  = 8'h80;
    e_wdata = 8'h3C;
    e_we    = 1'b1;
    e_req   = 1'b1;
    sb_q.push_back('{1'b1, 8'h00});
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (mem_we !== (c == 1) || e_ack !== (c == 2)) begin
        errors++; $display("FAIL write_timing c%0d: got we%b ack%b expected we%b ack%b", c, mem_we, e_ack, (c == 1), (c == 2));
      end
      if (c == 1) begin
        checks++;
        if ({mem_addr, mem_wdata} !== 16'h803C) begin
          errors++; $display("FAIL write_bus: got %h expected 803c", {mem_addr, mem_wdata});
        end
      end
      if (f_ack || e_ack) begin
        checks++;
        e = sb_q.pop_front();
        if (e_ack !== e.is_e || e_rdata !== e.data) begin
          errors++; $display("FAIL write_sb: got e%b %h expected e%b %h", e_ack, e_rdata, e.is_e, e.data);
        end
      end
      if (c == 2) e_req = 1'b0;
      $display("write c%0d mem_we=%b e_ack=%b", c, mem_we, e_ack);
    end
    @(posedge clk);
    #1;
    e_we  = 1'b0;
    e_req = 1'b1;
    sb_q.push_back('{1'b1, 8'h3C});
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b0 || e_ack !== (c == 3)) begin
        errors++; $display("FAIL read_timing c%0d: got we%b ack%b expected we0 ack%b", c, mem_we, e_ack, (c == 3));
      end
      if (e_ack) begin
        checks++;
        e = sb_q.pop_front();
        if (e_rdata !== e.data || f_rdata !== 8'hA5) begin
          errors++; $display("FAIL read_sb: got e_rdata %h f_rdata %h expected %h a5", e_rdata, f_rdata, e.data);
        end
        e_req = 1'b0;
      end
      $display("read c%0d e_ack=%b e_rdata=%h", c, e_ack, e_rdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_rr_alternation();
    exp_t e;
    int   acks;
    int   last_ack;
    acks     = 0;
    last_ack = -1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    f_addr = 8'h21;
    e_addr = 8'h42;
    e_we   = 1'b0;
    f_req  = 1'b1;
    e_req  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back('{1'b0, 8'h21 ^ 8'hB5});
      sb_q.push_back('{1'b1, 8'h42 ^ 8'hB5});
    end
    for (int c = 0; c < 40 && acks < 4; c++) begin
      @(negedge clk);
      checks++;
      if (f_ack && e_ack) begin
        errors++; $display("FAIL rr_dual_ack c%0d: got 11 expected one ack", c);
      end
      if (f_ack || e_ack) begin
        checks++;
        if (c - last_ack != 4) begin
          errors++; $display("FAIL rr_spacing: got %0d expected 4", c - last_ack);
        end
        last_ack = c;
        acks++;
        checks++;
        e = sb_q.pop_front();
        if (e_ack !== e.is_e || (e.is_e ? e_rdata : f_rdata) !== e.data) begin
          errors++; $display("FAIL rr_sb #%0d: got e%b %h expected e%b %h", acks, e_ack, (e.is_e ? e_rdata : f_rdata), e.is_e, e.data);
        end
        $display("rr ack #%0d c%0d owner=%s", acks, c, e_ack ? "exec" : "fetch");
        if (acks == 4) begin
          f_req = 1'b0;
          e_req = 1'b0;
        end
      end
    end
    checks++;
    if (acks != 4) begin
      errors++; $display("FAIL rr_count: got %0d expected 4", acks);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || f_ack !== 1'b0 || e_ack !== 1'b0) begin
        errors++; $display("FAIL rr_idle c%0d: got busy%b f%b e%b expected 000", c, busy, f_ack, e_ack);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    f_addr = 8'h33;
    f_req  = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL mid_busy: got %b expected 1", busy);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, f_ack, e_ack, mem_we, mem_addr, mem_wdata, f_rdata, e_rdata} !== 36'h0) begin
      errors++; $display("FAIL mid_reset_outs: got %h expected 0", {busy, f_ack, e_ack, mem_we, mem_addr, mem_wdata, f_rdata, e_rdata});
    end
    @(negedge clk);
    checks++;
    if (f_ack !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_no_ack: got f%b busy%b expected 00", f_ack, busy);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb_q.push_back('{1'b0, 8'h33 ^ 8'hB5});
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (f_ack !== (c == 3)) begin
        errors++; $display("FAIL mid_restart_ack c%0d: got %b expected %b", c, f_ack, (c == 3));
      end
      if (c == 1) begin
        checks++;
        if (mem_addr !== 8'h33) begin
          errors++; $display("FAIL mid_restart_addr: got %h expected 33", mem_addr);
        end
      end
      if (f_ack) begin
        checks++;
        e = sb_q.pop_front();
        if (f_rdata !== e.data) begin
          errors++; $display("FAIL mid_restart_data: got %h expected %h", f_rdata, e.data);
        end
        f_req = 1'b0;
      end
      $display("reset_mid restart c%0d f_ack=%b f_rdata=%h", c, f_ack, f_rdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_fixed_priority();
    int f_cnt;
    bit e_seen;
    f_cnt    = 0;
    e_seen   = 1'b0;
    p_f_addr = 8'h01;
    p_e_addr = 8'h02;
    p_e_we   = 1'b0;
    p_f_req  = 1'b1;
    p_e_req  = 1'b1;
    for (int c = 0; c < 60 && !e_seen; c++) begin
      @(negedge clk);
      if (p_e_ack) begin
        e_seen = 1'b1;
        p_e_req = 1'b0;
        checks++;
        if (f_cnt != 3 || c != 15) begin
          errors++; $display("FAIL fp_exec_when: got c%0d after %0d fetches expected c15 after 3", c, f_cnt);
        end
        checks++;
        if (p_e_rdata !== (8'h02 ^ 8'hB5)) begin
          errors++; $display("FAIL fp_exec_data: got %h expected %h", p_e_rdata, 8'h02 ^ 8'hB5);
        end
        $display("fp exec ack c%0d e_rdata=%h", c, p_e_rdata);
      end
      if (p_f_ack) begin
        f_cnt++;
        checks++;
        if (p_f_rdata !== (8'h01 ^ 8'hB5) || c != 4 * f_cnt - 1) begin
          errors++; $display("FAIL fp_fetch: got %h at c%0d expected %h at c%0d", p_f_rdata, c, 8'h01 ^ 8'hB5, 4 * f_cnt - 1);
        end
        $display("fp fetch ack #%0d c%0d f_rdata=%h", f_cnt, c, p_f_rdata);
        if (f_cnt == 3) p_f_req = 1'b0;
      end
    end
    checks++;
    if (!e_seen || f_cnt != 3) begin
      errors++; $display("FAIL fp_complete: got exec %b fetches %0d expected 1 3", e_seen, f_cnt);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    {f_req, e_req, e_we} = 3'b0;
    f_addr = '0; e_addr = '0; e_wdata = '0;
    {p_f_req, p_e_req, p_e_we} = 3'b0;
    p_f_addr = '0; p_e_addr = '0; p_e_wdata = '0;
    test_reset();
    test_single_fetch();
    test_write_read();
    test_rr_alternation();
    test_reset_mid();
    test_fixed_priority();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
